regfile_rd_port: RTL and testbench

//  Read side of the CPU register file: an 8 x 16-bit register array with one write port and a

---
 rtl/regfile_rd_port_if.sv | 28 ++
 rtl/regfile_rd_port.sv | 112 +++++++++++
 tb/tb_regfile_rd_port.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/regfile_rd_port_if.sv
// Bus bundle for the register-file read port: write strobe, read request and read response.
// master = decode/execute side, slave = register file.
interface regfile_rd_port_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 3
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              rd_req_valid;
  logic              rd_req_ready;
  logic [ADDR_W-1:0] rd_addr1;
  logic [ADDR_W-1:0] rd_addr2;
  logic              rd_rsp_valid;
  logic              rd_rsp_ready;
  logic [DATA_W-1:0] rd_data1;
  logic [DATA_W-1:0] rd_data2;

  modport master (
    output wr_en, wr_addr, wr_data, rd_req_valid, rd_addr1, rd_addr2, rd_rsp_ready,
    input  rd_req_ready, rd_rsp_valid, rd_data1, rd_data2
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_req_valid, rd_addr1, rd_addr2, rd_rsp_ready,
    output rd_req_ready, rd_rsp_valid, rd_data1, rd_data2
  );
endinterface

// File: rtl/regfile_rd_port.sv
// 8 x 16 register file with write-to-read bypass and a 2-entry (output + skid)
// response buffer so one read per cycle survives consumer backpressure.
module regfile_rd_port #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned NUM_REGS = 8,
  parameter int unsigned ADDR_W   = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  regfile_rd_port_if.slave      bus
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic [DATA_W-1:0] out1_q, out1_d, out2_q, out2_d;
  logic [DATA_W-1:0] skid1_q, skid1_d, skid2_q, skid2_d;
  logic              rsp_valid_q, rsp_valid_d;

  logic              req_ready_c;
  logic              acc_c, pop_c;
  logic [DATA_W-1:0] op1_c, op2_c;

  // Ready depends only on reset and buffer occupancy, never on rd_rsp_ready.
  assign req_ready_c = !rst && (state_q != ST_FULL);
  assign acc_c       = bus.rd_req_valid && req_ready_c;
  assign pop_c       = rsp_valid_q && bus.rd_rsp_ready;

  // Operand snapshot: R0 reads zero, a same-cycle write is forwarded.
  always_comb begin
    op1_c = regs_q[bus.rd_addr1];
    op2_c = regs_q[bus.rd_addr2];
    if (bus.wr_en && (bus.wr_addr == bus.rd_addr1)) op1_c = bus.wr_data;
    if (bus.wr_en && (bus.wr_addr == bus.rd_addr2)) op2_c = bus.wr_data;
    if (bus.rd_addr1 == '0) op1_c = '0;
    if (bus.rd_addr2 == '0) op2_c = '0;
  end

  // Register array update and buffer occupancy FSM.
  always_comb begin
    state_d = state_q;
    regs_d  = regs_q;
    out1_d  = out1_q;
    out2_d  = out2_q;
    skid1_d = skid1_q;
    skid2_d = skid2_q;

    if (bus.wr_en && (bus.wr_addr != '0)) regs_d[bus.wr_addr] = bus.wr_data;

    case (state_q)
      ST_EMPTY: begin
        if (acc_c) begin
          out1_d  = op1_c;
          out2_d  = op2_c;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (acc_c && pop_c) begin
          out1_d = op1_c;
          out2_d = op2_c;
        end else if (acc_c) begin
          skid1_d = op1_c;
          skid2_d = op2_c;
          state_d = ST_FULL;
        end else if (pop_c) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (pop_c) begin
          out1_d  = skid1_q;
          out2_d  = skid2_q;
          state_d = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase

    rsp_valid_d = (state_d != ST_EMPTY);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      rsp_valid_q <= 1'b0;
      out1_q      <= '0;
      out2_q      <= '0;
      skid1_q     <= '0;
      skid2_q     <= '0;
      for (int i = 0; i < int'(NUM_REGS); i++) regs_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= rsp_valid_d;
      out1_q      <= out1_d;
      out2_q      <= out2_d;
      skid1_q     <= skid1_d;
      skid2_q     <= skid2_d;
      regs_q      <= regs_d;
    end
  end

  assign bus.rd_req_ready = req_ready_c;
  assign bus.rd_rsp_valid = rsp_valid_q;
  assign bus.rd_data1     = out1_q;
  assign bus.rd_data2     = out2_q;

endmodule

// File: tb/tb_regfile_rd_port.sv
// Self-checking bench for regfile_rd_port: directed scenarios then random traffic,
// compared against a queue-based model of the register file and response buffer.
module tb_regfile_rd_port;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_rd_port_if #(.DATA_W(16), .ADDR_W(3)) bus ();

  regfile_rd_port #(.DATA_W(16), .NUM_REGS(8), .ADDR_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [15:0] d1;
    logic [15:0] d2;
  } rsp_t;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] m_regs [8];
  rsp_t        m_q [$];
  rsp_t        m_hold;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, check outputs against the model, then advance the model.
  task automatic cyc(input logic r, input logic we, input logic [2:0] wa, input logic [15:0] wd,
                     input logic rv, input logic [2:0] a1, input logic [2:0] a2,
                     input logic rr, input bit chk);
    logic m_ready, m_valid, acc, pop;
    rsp_t nr, exp_out;
    rst              = r;
    bus.wr_en        = we;
    bus.wr_addr      = wa;
    bus.wr_data      = wd;
    bus.rd_req_valid = rv;
    bus.rd_addr1     = a1;
    bus.rd_addr2     = a2;
    bus.rd_rsp_ready = rr;
    #1;
    m_valid = (m_q.size() > 0);
    m_ready = !r && (m_q.size() < 2);
    exp_out = m_valid ? m_q[0] : m_hold;
    if (chk) begin
      check("rd_req_ready", 32'(bus.rd_req_ready), 32'(m_ready));
      check("rd_rsp_valid", 32'(bus.rd_rsp_valid), 32'(m_valid));
      check("rd_data1", 32'(bus.rd_data1), 32'(exp_out.d1));
      check("rd_data2", 32'(bus.rd_data2), 32'(exp_out.d2));
    end
    acc   = rv && m_ready;
    pop   = m_valid && rr;
    nr.d1 = (a1 == 3'd0) ? 16'h0 : ((we && wa == a1) ? wd : m_regs[a1]);
    nr.d2 = (a2 == 3'd0) ? 16'h0 : ((we && wa == a2) ? wd : m_regs[a2]);
    @(posedge clk);
    if (r) begin
      m_q.delete();
      foreach (m_regs[i]) m_regs[i] = 16'h0;
      m_hold = '0;
    end else begin
      if (pop) void'(m_q.pop_front());
      if (acc) m_q.push_back(nr);
      if (we && wa != 3'd0) m_regs[wa] = wd;
      if (m_q.size() > 0) m_hold = m_q[0];
    end
    @(negedge clk);
  endtask

  task automatic idle(input logic rr);
    cyc(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'd0, rr, 1'b1);
  endtask

  task automatic rd(input logic [2:0] a1, input logic [2:0] a2, input logic rr);
    cyc(1'b0, 1'b0, 3'd0, 16'h0, 1'b1, a1, a2, rr, 1'b1);
  endtask

  task automatic wr(input logic [2:0] wa, input logic [15:0] wd);
    cyc(1'b0, 1'b1, wa, wd, 1'b0, 3'd0, 3'd0, 1'b1, 1'b1);
  endtask

  initial begin
    foreach (m_regs[i]) m_regs[i] = 16'h0;
    m_hold = '0;

    // Reset for two cycles with a pending read request, then read r1,r7.
    cyc(1'b1, 1'b0, 3'd0, 16'h0, 1'b1, 3'd1, 3'd7, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 3'd0, 16'h0, 1'b1, 3'd1, 3'd7, 1'b1, 1'b1);
    rd(3'd1, 3'd7, 1'b1);
    idle(1'b1);

    // Write then read; R0 reads zero.
    wr(3'd3, 16'hBEEF);
    rd(3'd3, 3'd0, 1'b1);
    idle(1'b1);

    // Same-cycle bypass, and writes to R0 dropped.
    cyc(1'b0, 1'b1, 3'd5, 16'h1234, 1'b1, 3'd5, 3'd5, 1'b1, 1'b1);
    idle(1'b1);
    wr(3'd0, 16'hFFFF);
    rd(3'd0, 3'd0, 1'b1);
    idle(1'b1);

    // Backpressure: A and B buffered, third request refused, drain in order.
    rd(3'd3, 3'd5, 1'b0);
    rd(3'd5, 3'd3, 1'b0);
    rd(3'd1, 3'd1, 1'b0);
    idle(1'b0);
    rd(3'd1, 3'd2, 1'b1);
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);

    // Back-to-back reads r1..r7 at full rate.
    for (int i = 1; i < 8; i++) wr(3'(i), 16'(16'h1100 * i + i));
    for (int i = 1; i < 8; i++) rd(3'(i), 3'(8 - i), 1'b1);
    idle(1'b1);
    idle(1'b1);

    // Hold FULL, overwrite the buffered source registers, then reset mid-operation.
    rd(3'd2, 3'd4, 1'b0);
    rd(3'd4, 3'd2, 1'b0);
    wr(3'd2, 16'hAAAA);
    cyc(1'b0, 1'b1, 3'd4, 16'h5555, 1'b0, 3'd0, 3'd0, 1'b0, 1'b1);
    idle(1'b0);
    cyc(1'b1, 1'b0, 3'd0, 16'h0, 1'b1, 3'd2, 3'd4, 1'b0, 1'b1);
    idle(1'b1);
    rd(3'd2, 3'd4, 1'b1);
    idle(1'b1);

    // Random traffic with occasional reset.
    for (int n = 0; n < 600; n++) begin
      cyc(1'($urandom_range(0, 99) == 0), 1'($urandom_range(0, 1)),
          3'($urandom_range(0, 7)), 16'($urandom),
          1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
          1'($urandom_range(0, 2) != 0), 1'b1);
    end
    idle(1'b1);
    idle(1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
